// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst types, response codes and the AxSIZE encoder.
// Used by both the burst reader and the burst writer.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Bytes per beat -> AxSIZE; nbytes must be a power of two up to 128.
  function automatic logic [2:0] axsize(input int unsigned nbytes);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (nbytes == (32'd1 << i)) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi4_full_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the writer (master) and a memory slave.
interface axi4_full_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     m_awid;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]              m_awlen;
  logic [2:0]              m_awsize;
  logic [1:0]              m_awburst;
  logic [2:0]              m_awprot;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [ID_WIDTH-1:0]     m_bid;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awprot, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bid, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awprot, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bid, m_bresp, m_bvalid
  );

endinterface

// File: rtl/axi4_full_writer.sv
// AXI4-Full burst writer: splits a word stream into aligned INCR bursts of at most
// BURST_LEN beats, issuing AW, then W, then waiting for B, one burst at a time.
module axi4_full_writer
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [15:0]           write_length,
  input  logic                  start_write,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  axi4_full_writer_if.master    m_axi
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2 = $clog2(BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND_AW, ST_SEND_W, ST_WAIT_B, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  in_w_q, in_w_d;
  logic                  bready_q, bready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;

  logic [15:0]           words_next;
  logic                  last_beat;
  logic                  w_fire;
  logic [ID_WIDTH-1:0]   unused_bid;

  function automatic logic [8:0] clip_beats(input logic [15:0] words);
    return (words > 16'(BURST_LEN)) ? 9'(BURST_LEN) : words[8:0];
  endfunction

  assign words_next = words_left_q - 16'(beats_q);
  assign last_beat  = (beat_cnt_q == beats_q - 9'd1);
  assign w_fire     = in_w_q && data_valid && m_axi.m_wready;
  assign unused_bid = m_axi.m_bid;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    beats_d      = beats_q;
    beat_cnt_d   = beat_cnt_q;
    awvalid_d    = awvalid_q;
    in_w_d       = in_w_q;
    bready_d     = bready_q;
    done_d       = 1'b0;
    error_d      = error_q;
    busy_d       = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_write) begin
          busy_d  = 1'b1;
          error_d = 1'b0;
          if (write_length != 16'd0) begin
            addr_d       = write_addr;
            words_left_d = write_length;
            beats_d      = clip_beats(write_length);
            awvalid_d    = 1'b1;
            state_d      = ST_SEND_AW;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND_AW: begin
        if (m_axi.m_awready) begin
          awvalid_d  = 1'b0;
          in_w_d     = 1'b1;
          beat_cnt_d = 9'd0;
          state_d    = ST_SEND_W;
        end
      end
      ST_SEND_W: begin
        if (w_fire) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) begin
            in_w_d   = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_WAIT_B;
          end
        end
      end
      ST_WAIT_B: begin
        if (m_axi.m_bvalid) begin
          bready_d     = 1'b0;
          error_d      = error_q || (m_axi.m_bresp != RESP_OKAY);
          words_left_d = words_next;
          addr_d       = addr_q + (ADDR_WIDTH'(beats_q) << SIZE_LOG2);
          if (words_next == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            beats_d   = clip_beats(words_next);
            awvalid_d = 1'b1;
            state_d   = ST_SEND_AW;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      beats_q      <= 9'd1;
      beat_cnt_q   <= '0;
      awvalid_q    <= 1'b0;
      in_w_q       <= 1'b0;
      bready_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      beats_q      <= beats_d;
      beat_cnt_q   <= beat_cnt_d;
      awvalid_q    <= awvalid_d;
      in_w_q       <= in_w_d;
      bready_q     <= bready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign write_done  = done_q;
  assign write_error = error_q;
  assign busy        = busy_q;

  assign m_axi.m_awid    = '0;
  assign m_axi.m_awaddr  = addr_q;
  assign m_axi.m_awlen   = 8'(beats_q - 9'd1);
  assign m_axi.m_awsize  = axsize(BYTES);
  assign m_axi.m_awburst = BURST_INCR;
  assign m_axi.m_awprot  = 3'b000;
  assign m_axi.m_awvalid = awvalid_q;

  // The W channel is a straight pass-through of the stream, opened only while in_w_q.
  assign m_axi.m_wdata  = data_in;
  assign m_axi.m_wstrb  = '1;
  assign m_axi.m_wlast  = in_w_q && last_beat;
  assign m_axi.m_wvalid = in_w_q && data_valid;
  assign data_ready     = in_w_q && m_axi.m_wready;

  assign m_axi.m_bready = bready_q;

endmodule

// File: tb/tb_axi4_full_writer.sv
// Randomised bench for axi4_full_writer: a slave/memory model plus a transfer-level
// reference that predicts bursts, handshake gating, done, busy and error each cycle.
`timescale 1ns/1ps
module tb_axi4_full_writer;
  import axi_pkg::*;

  localparam int AW = 32, DW = 64, IW = 4, BL = 16, BYTES = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] write_addr;
  logic [15:0]   write_length;
  logic          start_write;
  logic          write_done, write_error, busy;
  logic [DW-1:0] data_in;
  logic          data_valid, data_ready;

  axi4_full_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  axi4_full_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_addr  (write_addr),
    .write_length(write_length),
    .start_write (start_write),
    .write_done  (write_done),
    .write_error (write_error),
    .busy        (busy),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .m_axi       (axi)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; int beats; } burst_t;

  burst_t        exp_bursts[$];
  logic [DW-1:0] src[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            src_ptr, aw_idx, b_idx, beat, cur_len, b_pending;
  logic [AW-1:0] cur_addr;
  bit            w_phase, exp_aw, exp_busy, exp_done, exp_err, started;
  int            wlast_cnt, aw_cnt, beats_total;
  int            aw_rate, w_rate, v_rate, b_rate, err_burst;
  logic [1:0]    err_code;
  bit            poke;
  bit            prev_stall;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;

  task automatic model_reset();
    exp_bursts.delete();
    src_ptr = 0; aw_idx = 0; b_idx = 0; beat = 0; cur_len = 0; b_pending = 0;
    w_phase = 0; exp_aw = 0; exp_busy = 0; exp_done = 0; exp_err = 0; started = 0;
    wlast_cnt = 0; aw_cnt = 0; beats_total = 0; prev_stall = 0;
  endtask

  // Checks the current cycle and advances the model to the next cycle; called at negedge.
  task automatic monitor();
    bit nx_aw, nx_busy, nx_done, nx_err, nx_w;
    int nx_bp;
    bit want_last;
    nx_aw = exp_aw; nx_busy = exp_busy; nx_done = 1'b0; nx_err = exp_err;
    nx_w = w_phase; nx_bp = b_pending;

    check("busy", busy, exp_busy);
    check("write_done", write_done, exp_done);
    check("write_error", write_error, exp_err);
    check("awvalid", axi.m_awvalid, exp_aw);
    check("wvalid", axi.m_wvalid, w_phase && data_valid);
    check("data_ready", data_ready, w_phase && axi.m_wready);
    check("bready", axi.m_bready, b_pending != 0);

    if (prev_stall && axi.m_awvalid) begin
      check("aw_stable_addr", axi.m_awaddr, prev_awaddr);
      check("aw_stable_len", axi.m_awlen, prev_awlen);
    end
    prev_stall  = axi.m_awvalid && !axi.m_awready;
    prev_awaddr = axi.m_awaddr;
    prev_awlen  = axi.m_awlen;

    if (axi.m_awvalid && axi.m_awready && aw_idx < exp_bursts.size()) begin
      check("awaddr", axi.m_awaddr, exp_bursts[aw_idx].addr);
      check("awlen", axi.m_awlen, exp_bursts[aw_idx].beats - 1);
      check("awsize", axi.m_awsize, 3);
      check("awburst", axi.m_awburst, 1);
      check("awid", axi.m_awid, 0);
      check("awprot", axi.m_awprot, 0);
      cur_addr = exp_bursts[aw_idx].addr;
      cur_len  = exp_bursts[aw_idx].beats;
      aw_idx++; aw_cnt++;
      beat = 0; nx_aw = 0; nx_w = 1;
    end

    if (axi.m_wvalid && axi.m_wready && w_phase) begin
      want_last = (beat == cur_len - 1);
      check("wdata", axi.m_wdata, src[src_ptr]);
      check("wstrb", axi.m_wstrb, 8'hFF);
      check("wlast", axi.m_wlast, want_last);
      if (axi.m_wlast) wlast_cnt++;
      mem[cur_addr + AW'(beat * BYTES)] = axi.m_wdata;
      src_ptr++; beat++; beats_total++;
      if (want_last) begin
        nx_w = 0; nx_bp++;
      end
    end

    if (axi.m_bvalid && axi.m_bready && b_pending != 0) begin
      if (axi.m_bresp != 2'b00) nx_err = 1;
      b_idx++; nx_bp--;
      if (b_idx == exp_bursts.size()) nx_done = 1;
      else nx_aw = 1;
    end

    if (exp_done) nx_busy = 0;

    if (start_write && !exp_busy) begin
      nx_busy = 1; nx_err = 0; started = 1;
      exp_bursts.delete();
      for (int off = 0; off < int'(write_length); off += BL)
        exp_bursts.push_back('{write_addr + AW'(off * BYTES),
                               (int'(write_length) - off < BL) ? int'(write_length) - off : BL});
      if (write_length == 0) nx_done = 1;
      else nx_aw = 1;
    end

    exp_aw = nx_aw; exp_busy = nx_busy; exp_done = nx_done; exp_err = nx_err;
    w_phase = nx_w; b_pending = nx_bp;
  endtask

  task automatic drive();
    axi.m_awready = ($urandom_range(99) < aw_rate);
    axi.m_wready  = ($urandom_range(99) < w_rate);
    if (src_ptr < src.size() && $urandom_range(99) < v_rate) begin
      data_valid = 1'b1; data_in = src[src_ptr];
    end else begin
      data_valid = 1'b0; data_in = {$urandom, $urandom};
    end
    axi.m_bid = IW'($urandom);
    if (b_pending != 0 && $urandom_range(99) < b_rate) begin
      axi.m_bvalid = 1'b1;
      axi.m_bresp  = (b_idx == err_burst) ? err_code : 2'b00;
    end else begin
      axi.m_bvalid = 1'b0;
      axi.m_bresp  = 2'($urandom);
    end
    start_write = 1'b0;
    if (poke && exp_busy && $urandom_range(99) < 10) begin
      start_write  = 1'b1;
      write_addr   = $urandom & ~32'h7F;
      write_length = 16'($urandom_range(1, 60));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_outputs_low(input string t);
    check({t, "_awvalid"}, axi.m_awvalid, 0);
    check({t, "_wvalid"}, axi.m_wvalid, 0);
    check({t, "_data_ready"}, data_ready, 0);
    check({t, "_bready"}, axi.m_bready, 0);
    check({t, "_done"}, write_done, 0);
    check({t, "_error"}, write_error, 0);
    check({t, "_busy"}, busy, 0);
  endtask

  // One transfer from start pulse to idle; called just after a rising edge.
  task automatic run_xfer(input logic [AW-1:0] addr, input int len, input bit seq,
                          input int awr, input int wr, input int vr, input int br,
                          input int eb, input logic [1:0] ec, input bit pk, input int rst_beat);
    bit finished;
    logic [AW-1:0] a;
    bit keep_err;
    keep_err = exp_err;
    model_reset();
    exp_err = keep_err;
    mem.delete(); src.delete();
    for (int i = 0; i < len; i++) src.push_back(seq ? DW'(i) : {$urandom, $urandom});
    aw_rate = awr; w_rate = wr; v_rate = vr; b_rate = br;
    err_burst = eb; err_code = ec; poke = pk;
    drive();
    start_write = 1'b1; write_addr = addr; write_length = 16'(len);
    finished = 0;
    for (int n = 0; n < 5000 && !finished; n++) begin
      cycle();
      if (rst_beat >= 0 && beats_total == rst_beat) begin
        #1 rst = 1'b1;
        #1 check_outputs_low("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_err = 0;
        @(posedge clk); #1;
        start_write = 1'b0; data_valid = 1'b0; axi.m_bvalid = 1'b0;
        return;
      end
      if (started && !exp_busy) finished = 1;
    end
    check("xfer_finished", finished, 1);
    check("aw_count", aw_cnt, exp_bursts.size());
    check("wlast_count", wlast_cnt, exp_bursts.size());
    check("beat_count", beats_total, len);
    check("mem_words", mem.size(), len);
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i * BYTES);
      if (mem.exists(a)) check($sformatf("mem_%0d", i), mem[a], src[i]);
      else check($sformatf("mem_missing_%0d", i), 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; start_write = 1'b0; write_addr = '0; write_length = '0;
    data_in = '0; data_valid = 1'b0;
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0;
    axi.m_bresp = 2'b00; axi.m_bid = '0;
    model_reset();
    #12 check_outputs_low("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full single burst, sequential data, slave always ready.
    run_xfer(32'h1000, 16, 1, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    // Three bursts with a 5-beat remainder.
    run_xfer(32'h1000, 37, 0, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    // Address wraps past the top of the address space.
    run_xfer(32'hFFFF_FF80, 37, 0, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    // Backpressure on every channel, with starts thrown in while busy.
    for (int t = 0; t < 8; t++)
      run_xfer($urandom & ~32'h7F, $urandom_range(1, 70), 0, $urandom_range(30, 90),
               $urandom_range(30, 90), $urandom_range(30, 90), $urandom_range(30, 90),
               -1, 2'b00, 1, -1);
    // SLVERR on the second of three bursts; error sticks, next start clears it.
    run_xfer(32'h2000, 40, 0, 70, 70, 80, 60, 1, 2'b10, 0, -1);
    run_xfer(32'h3000, 5, 0, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    // DECERR on the last burst under backpressure.
    run_xfer(32'h4000, 33, 0, 50, 50, 50, 50, 2, 2'b11, 1, -1);
    // Zero and one word.
    run_xfer(32'h5000, 0, 0, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    run_xfer(32'h5000, 1, 0, 100, 100, 100, 100, -1, 2'b00, 0, -1);
    // Reset during beat 5, then a normal transfer.
    run_xfer(32'h6000, 40, 0, 100, 100, 100, 100, -1, 2'b00, 0, 5);
    check_outputs_low("after_rst");
    run_xfer(32'h7000, 20, 0, 60, 60, 60, 60, -1, 2'b00, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
